// File: rtl/sram_arbiter.sv
// Two-port arbiter and sequencer for the board's 256Kx16 asynchronous SRAM.
// Round-robin between CPU (c_*) and DMA (d_*); strobes come straight from registers.
`timescale 1ns/1ps

module sram_arbiter #(
    parameter int AW          = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          CLOCK_50,
    input  logic          nreset,

    input  logic          c_req,
    input  logic [1:0]    c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [15:0]   c_wdata,
    output logic [15:0]   c_rdata,
    output logic          c_ack,

    input  logic          d_req,
    input  logic [1:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [15:0]   d_wdata,
    output logic [15:0]   d_rdata,
    output logic          d_ack,

    output logic [AW-1:0] sram_addr,
    output logic [15:0]   sram_dq_out,
    output logic          sram_dq_oe,
    input  logic [15:0]   sram_dq_in,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n,

    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [1:0]    we_lat, we_nxt;
    logic          last_d, last_nxt;
    logic          pick_d;
    logic [AW-1:0] addr_nxt;
    logic [15:0]   dout_nxt;
    logic [1:0]    grant_nxt;
    logic [15:0]   c_rdata_nxt, d_rdata_nxt;
    logic          c_ack_nxt, d_ack_nxt;
    logic          ce_n_nxt, oe_n_nxt, we_n_nxt, ub_n_nxt, lb_n_nxt, dq_oe_nxt;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        we_nxt      = we_lat;
        last_nxt    = last_d;
        pick_d      = 1'b0;
        addr_nxt    = sram_addr;
        dout_nxt    = sram_dq_out;
        grant_nxt   = grant;
        c_rdata_nxt = c_rdata;
        d_rdata_nxt = d_rdata;
        c_ack_nxt   = 1'b0;
        d_ack_nxt   = 1'b0;
        ce_n_nxt    = 1'b1;
        oe_n_nxt    = 1'b1;
        we_n_nxt    = 1'b1;
        ub_n_nxt    = 1'b1;
        lb_n_nxt    = 1'b1;
        dq_oe_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (c_req || d_req) begin
                    // On contention the port that did not win last time goes first.
                    pick_d    = d_req && (!c_req || !last_d);
                    addr_nxt  = pick_d ? d_addr  : c_addr;
                    dout_nxt  = pick_d ? d_wdata : c_wdata;
                    we_nxt    = pick_d ? d_we    : c_we;
                    grant_nxt = pick_d ? 2'b10   : 2'b01;
                    last_nxt  = pick_d;
                    cnt_nxt   = WAIT_LOAD;
                    state_nxt = ACCESS;
                end else begin
                    grant_nxt = '0;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                    c_ack_nxt = grant[0];
                    d_ack_nxt = grant[1];
                    if (we_lat == 2'b00) begin
                        if (grant[0]) c_rdata_nxt = sram_dq_in;
                        if (grant[1]) d_rdata_nxt = sram_dq_in;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase

        // Strobes are decoded from the next state so they leave the flops glitch-free.
        case (state_nxt)
            ACCESS: begin
                ce_n_nxt = 1'b0;
                if (we_nxt == 2'b00) begin
                    oe_n_nxt = 1'b0;
                    ub_n_nxt = 1'b0;
                    lb_n_nxt = 1'b0;
                end else begin
                    we_n_nxt  = 1'b0;
                    ub_n_nxt  = ~we_nxt[1];
                    lb_n_nxt  = ~we_nxt[0];
                    dq_oe_nxt = 1'b1;
                end
            end
            DONE: begin
                ce_n_nxt  = 1'b0;
                dq_oe_nxt = (we_nxt != 2'b00);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            cnt         <= '0;
            we_lat      <= '0;
            last_d      <= 1'b1;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            grant       <= '0;
            c_rdata     <= '0;
            d_rdata     <= '0;
            c_ack       <= 1'b0;
            d_ack       <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            we_lat      <= we_nxt;
            last_d      <= last_nxt;
            sram_addr   <= addr_nxt;
            sram_dq_out <= dout_nxt;
            grant       <= grant_nxt;
            c_rdata     <= c_rdata_nxt;
            d_rdata     <= d_rdata_nxt;
            c_ack       <= c_ack_nxt;
            d_ack       <= d_ack_nxt;
            sram_ce_n   <= ce_n_nxt;
            sram_oe_n   <= oe_n_nxt;
            sram_we_n   <= we_n_nxt;
            sram_ub_n   <= ub_n_nxt;
            sram_lb_n   <= lb_n_nxt;
            sram_dq_oe  <= dq_oe_nxt;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two builds (WAIT_CYCLES 1 and 0) against behavioural SRAMs
// and a reference memory/arbitration model kept by the bench.
`timescale 1ns/1ps

module tb_sram_arbiter;

    logic clk = 1'b0;
    always #10 clk = ~clk;
    logic nreset;

    // WAIT_CYCLES = 1 instance
    logic        c_req, d_req, c_ack, d_ack;
    logic [1:0]  c_we, d_we, grant;
    logic [17:0] c_addr, d_addr, s_addr;
    logic [15:0] c_wdata, d_wdata, c_rdata, d_rdata, s_dq_out, s_dq_in;
    logic        s_dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

    // WAIT_CYCLES = 0 instance
    logic        c_req0, d_req0, c_ack0, d_ack0;
    logic [1:0]  c_we0, d_we0, grant0;
    logic [17:0] c_addr0, d_addr0, s_addr0;
    logic [15:0] c_wdata0, d_wdata0, c_rdata0, d_rdata0, s_dq_out0, s_dq_in0;
    logic        s_dq_oe0, ce_n0, oe_n0, we_n0, ub_n0, lb_n0;

    sram_arbiter #(.AW(18), .WAIT_CYCLES(1)) dut (
        .CLOCK_50(clk), .nreset(nreset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .sram_addr(s_addr), .sram_dq_out(s_dq_out), .sram_dq_oe(s_dq_oe), .sram_dq_in(s_dq_in),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n),
        .grant(grant)
    );

    sram_arbiter #(.AW(18), .WAIT_CYCLES(0)) dut0 (
        .CLOCK_50(clk), .nreset(nreset),
        .c_req(c_req0), .c_we(c_we0), .c_addr(c_addr0), .c_wdata(c_wdata0), .c_rdata(c_rdata0), .c_ack(c_ack0),
        .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0), .d_rdata(d_rdata0), .d_ack(d_ack0),
        .sram_addr(s_addr0), .sram_dq_out(s_dq_out0), .sram_dq_oe(s_dq_oe0), .sram_dq_in(s_dq_in0),
        .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0), .sram_ub_n(ub_n0), .sram_lb_n(lb_n0),
        .grant(grant0)
    );

    bit [15:0] mem1 [0:262143];
    bit [15:0] mem0 [0:262143];
    bit [15:0] ref1 [0:262143];

    // Undriven bus reads back as a recognisable pattern.
    assign s_dq_in  = (!ce_n  && !oe_n)  ? mem1[s_addr]  : 16'hDEAD;
    assign s_dq_in0 = (!ce_n0 && !oe_n0) ? mem0[s_addr0] : 16'hDEAD;

    int checks = 0;
    int failures = 0;
    int wen_cnt = 0, oen0_cnt = 0, cack_cnt = 0, dack_cnt = 0, bus_fight = 0, bad_grant = 0;
    logic [17:0] win_addr;
    logic [15:0] win_dq;
    logic        win_ub, win_lb, ack_dqoe;
    logic [1:0]  prev_grant = 2'b00;
    logic [1:0]  gseq [$];
    bit          model_last = 1'b1;

    always @(negedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) mem1[s_addr][7:0]  = s_dq_oe ? s_dq_out[7:0]  : 8'hEE;
            if (!ub_n) mem1[s_addr][15:8] = s_dq_oe ? s_dq_out[15:8] : 8'hEE;
            wen_cnt++;
            win_addr = s_addr;
            win_dq   = s_dq_out;
            win_ub   = ub_n;
            win_lb   = lb_n;
        end
        if (!oe_n && s_dq_oe) bus_fight++;
        if (c_ack) begin cack_cnt++; ack_dqoe = s_dq_oe; end
        if (d_ack) begin dack_cnt++; ack_dqoe = s_dq_oe; end
        if (grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(grant);
        if (grant == 2'b11) bad_grant++;
        prev_grant = grant;
        if (!ce_n0 && !we_n0) begin
            if (!lb_n0) mem0[s_addr0][7:0]  = s_dq_out0[7:0];
            if (!ub_n0) mem0[s_addr0][15:8] = s_dq_out0[15:8];
        end
        if (!oe_n0) oen0_cnt++;
    end

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd, input logic [1:0] we);
        return {we[1] ? wd[15:8] : old[15:8], we[0] ? wd[7:0] : old[7:0]};
    endfunction

    // One access on the WAIT_CYCLES=1 instance; lat counts edges from request to ack, -1 on timeout.
    task automatic run_access(input bit port, input logic [17:0] a, input logic [1:0] we,
                              input logic [15:0] wd, input bit disturb,
                              output logic [15:0] rd, output int lat);
        bit got = 0;
        @(posedge clk); #1;
        if (port) begin d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1; end
        else      begin c_addr = a; c_we = we; c_wdata = wd; c_req = 1'b1; end
        lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            lat++;
            if (disturb && lat == 1) begin
                #1;
                if (port) begin d_addr = 18'($urandom); d_wdata = 16'($urandom); d_we = 2'($urandom); d_req = 1'b0; end
                else      begin c_addr = 18'($urandom); c_wdata = 16'($urandom); c_we = 2'($urandom); c_req = 1'b0; end
            end
            @(negedge clk);
            if (port ? d_ack : c_ack) got = 1;
        end
        rd = port ? d_rdata : c_rdata;
        c_req = 1'b0;
        d_req = 1'b0;
        if (!got) lat = -1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ce_n, oe_n, we_n, ub_n, lb_n, s_dq_oe, c_ack, d_ack, grant} !== 10'b1111100000) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected %b", {ce_n, oe_n, we_n, ub_n, lb_n, s_dq_oe, c_ack, d_ack, grant}, 10'b1111100000);
        end
        checks++;
        if ({c_rdata, d_rdata, s_dq_out} !== 48'h0 || s_addr !== 18'h0) begin
            failures++;
            $display("FAIL reset_data: got %h %h %h addr %h expected zeros", c_rdata, d_rdata, s_dq_out, s_addr);
        end
        checks++;
        if ({ce_n0, oe_n0, we_n0, ub_n0, lb_n0, s_dq_oe0, c_ack0, d_ack0, grant0} !== 10'b1111100000) begin
            failures++;
            $display("FAIL reset_strobes_w0: got %b expected %b", {ce_n0, oe_n0, we_n0, ub_n0, lb_n0, s_dq_oe0, c_ack0, d_ack0, grant0}, 10'b1111100000);
        end
        nreset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({ce_n, oe_n, we_n, ub_n, lb_n, s_dq_oe, c_ack, d_ack, grant} !== 10'b1111100000) begin
                failures++;
                $display("FAIL idle_quiet cycle %0d: got %b expected %b", i, {ce_n, oe_n, we_n, ub_n, lb_n, s_dq_oe, c_ack, d_ack, grant}, 10'b1111100000);
            end
        end
    endtask

    task automatic test_word_write();
        logic [15:0] rd;
        int lat;
        wen_cnt = 0; cack_cnt = 0;
        run_access(1'b0, 18'h00010, 2'b11, 16'h1234, 1'b0, rd, lat);
        ref1[18'h00010] = merge(ref1[18'h00010], 16'h1234, 2'b11);
        model_last = 1'b0;
        @(negedge clk);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL ww_latency: got %0d expected 3", lat); end
        checks++;
        if (wen_cnt !== 2) begin failures++; $display("FAIL ww_we_n_width: got %0d expected 2", wen_cnt); end
        checks++;
        if (win_addr !== 18'h00010 || win_dq !== 16'h1234) begin
            failures++; $display("FAIL ww_bus: got addr %h data %h expected 00010 1234", win_addr, win_dq);
        end
        checks++;
        if (ack_dqoe !== 1'b1) begin failures++; $display("FAIL ww_dq_hold: got %b expected 1", ack_dqoe); end
        checks++;
        if (cack_cnt !== 1) begin failures++; $display("FAIL ww_ack_count: got %0d expected 1", cack_cnt); end
        checks++;
        if (mem1[18'h00010] !== 16'h1234) begin failures++; $display("FAIL ww_mem: got %h expected 1234", mem1[18'h00010]); end
    endtask

    task automatic test_byte_write_read();
        logic [15:0] rd, drd;
        int lat;
        run_access(1'b0, 18'h00010, 2'b01, 16'hABCD, 1'b0, rd, lat);
        ref1[18'h00010] = merge(ref1[18'h00010], 16'hABCD, 2'b01);
        checks++;
        if (win_ub !== 1'b1 || win_lb !== 1'b0) begin
            failures++; $display("FAIL bw_byte_lanes: got ub %b lb %b expected 1 0", win_ub, win_lb);
        end
        run_access(1'b0, 18'h00010, 2'b00, 16'h0000, 1'b0, rd, lat);
        checks++;
        if (rd !== 16'h12CD || lat !== 3) begin
            failures++; $display("FAIL bw_read: got %h lat %0d expected 12CD lat 3", rd, lat);
        end
        drd = d_rdata;
        run_access(1'b1, 18'h00020, 2'b11, 16'h5A5A, 1'b0, rd, lat);
        ref1[18'h00020] = 16'h5A5A;
        model_last = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (c_rdata !== 16'h12CD) begin failures++; $display("FAIL bw_rdata_hold: got %h expected 12CD", c_rdata); end
        checks++;
        if (d_rdata !== drd) begin failures++; $display("FAIL bw_d_rdata_untouched: got %h expected %h", d_rdata, drd); end
        checks++;
        if (mem1[18'h00020] !== 16'h5A5A) begin failures++; $display("FAIL bw_d_write: got %h expected 5A5A", mem1[18'h00020]); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_seq [$];
        int cl = 4, dl = 4, cdone = 0, ddone = 0;
        bit last = model_last, w;
        logic [15:0] cdat, ddat;
        while (cl > 0 || dl > 0) begin
            w = (cl > 0 && dl > 0) ? !last : (cl > 0 ? 1'b0 : 1'b1);
            exp_seq.push_back(w ? 2'b10 : 2'b01);
            if (w) dl--; else cl--;
            last = w;
        end
        gseq.delete(); cack_cnt = 0; dack_cnt = 0;
        cdat = 16'($urandom); ddat = 16'($urandom);
        @(posedge clk); #1;
        c_addr = 18'h00100; c_we = 2'b11; c_wdata = cdat; c_req = 1'b1;
        d_addr = 18'h20000; d_we = 2'b11; d_wdata = ddat; d_req = 1'b1;
        for (int i = 0; i < 200 && (cdone < 4 || ddone < 4); i++) begin
            @(negedge clk);
            if (c_ack) begin
                ref1[c_addr] = cdat; cdone++;
                if (cdone == 4) c_req = 1'b0;
                else begin cdat = 16'($urandom); c_addr = 18'h00100 + 18'(cdone); c_wdata = cdat; end
            end
            if (d_ack) begin
                ref1[d_addr] = ddat; ddone++;
                if (ddone == 4) d_req = 1'b0;
                else begin ddat = 16'($urandom); d_addr = 18'h20000 + 18'(ddone); d_wdata = ddat; end
            end
        end
        c_req = 1'b0; d_req = 1'b0;
        model_last = last;
        repeat (3) @(negedge clk);
        checks++;
        if (cack_cnt !== 4 || dack_cnt !== 4) begin
            failures++; $display("FAIL cont_acks: got c=%0d d=%0d expected 4 4", cack_cnt, dack_cnt);
        end
        checks++;
        if (gseq.size() !== 8) begin
            failures++; $display("FAIL cont_grant_count: got %0d expected 8", gseq.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (gseq[i] !== exp_seq[i]) begin
                    failures++; $display("FAIL cont_grant_order[%0d]: got %b expected %b", i, gseq[i], exp_seq[i]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem1[18'h00100 + 18'(i)] !== ref1[18'h00100 + 18'(i)] || mem1[18'h20000 + 18'(i)] !== ref1[18'h20000 + 18'(i)]) begin
                failures++; $display("FAIL cont_mem[%0d]: got %h %h expected %h %h", i, mem1[18'h00100 + 18'(i)],
                    mem1[18'h20000 + 18'(i)], ref1[18'h00100 + 18'(i)], ref1[18'h20000 + 18'(i)]);
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] pool [8];
        logic [15:0] rd, other;
        logic [17:0] a;
        logic [1:0]  we;
        logic [15:0] wd;
        bit port;
        int lat;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 18'($urandom);
            if (pool[i] == 18'h00155) pool[i] = 18'h3FFFF;
        end
        bus_fight = 0; bad_grant = 0;
        for (int n = 0; n < 40; n++) begin
            port = 1'($urandom);
            a = pool[$urandom_range(7, 0)];
            we = 2'($urandom);
            wd = 16'($urandom);
            other = port ? c_rdata : d_rdata;
            run_access(port, a, we, wd, 1'($urandom), rd, lat);
            model_last = port;
            checks++;
            if (lat !== 3) begin failures++; $display("FAIL rnd_latency[%0d]: got %0d expected 3", n, lat); end
            if (we == 2'b00) begin
                checks++;
                if (rd !== ref1[a]) begin failures++; $display("FAIL rnd_read[%0d] addr %h: got %h expected %h", n, a, rd, ref1[a]); end
            end else begin
                ref1[a] = merge(ref1[a], wd, we);
            end
            checks++;
            if ((port ? c_rdata : d_rdata) !== other) begin
                failures++; $display("FAIL rnd_other_rdata[%0d]: got %h expected %h", n, port ? c_rdata : d_rdata, other);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem1[pool[i]] !== ref1[pool[i]]) begin
                failures++; $display("FAIL rnd_mem addr %h: got %h expected %h", pool[i], mem1[pool[i]], ref1[pool[i]]);
            end
        end
        checks++;
        if (bus_fight !== 0 || bad_grant !== 0) begin
            failures++; $display("FAIL rnd_bus_rules: got fights %0d bad grants %0d expected 0 0", bus_fight, bad_grant);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        int lat;
        int cdone = 0, ddone = 0;
        @(posedge clk); #1;
        c_addr = 18'h00155; c_we = 2'b11; c_wdata = 16'h5555; c_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (we_n !== 1'b0) begin failures++; $display("FAIL rm_in_write: got we_n %b expected 0", we_n); end
        #2 nreset = 1'b0;
        #1;
        checks++;
        if ({ce_n, oe_n, we_n, ub_n, lb_n, s_dq_oe, grant} !== 8'b11111000) begin
            failures++; $display("FAIL rm_async: got %b expected 11111000", {ce_n, oe_n, we_n, ub_n, lb_n, s_dq_oe, grant});
        end
        c_req = 1'b0;
        cack_cnt = 0; dack_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) nreset = 1'b1;
        model_last = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (cack_cnt !== 0 || dack_cnt !== 0) begin
            failures++; $display("FAIL rm_no_ack: got c=%0d d=%0d expected 0 0", cack_cnt, dack_cnt);
        end
        checks++;
        if (c_rdata !== 16'h0 || d_rdata !== 16'h0) begin
            failures++; $display("FAIL rm_rdata_clear: got %h %h expected 0000 0000", c_rdata, d_rdata);
        end
        gseq.delete();
        @(posedge clk); #1;
        c_addr = 18'h00010; c_we = 2'b00; c_req = 1'b1;
        d_addr = 18'h00020; d_we = 2'b00; d_req = 1'b1;
        for (int i = 0; i < 40 && (cdone == 0 || ddone == 0); i++) begin
            @(negedge clk);
            if (c_ack) begin cdone++; c_req = 1'b0; end
            if (d_ack) begin ddone++; d_req = 1'b0; end
        end
        c_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (gseq.size() !== 2 || gseq[0] !== 2'b01 || gseq[1] !== 2'b10) begin
            failures++; $display("FAIL rm_first_winner: got %0d grants first %b expected 2 grants first 01", gseq.size(), gseq.size() > 0 ? gseq[0] : 2'b00);
        end
        checks++;
        if (c_rdata !== ref1[18'h00010] || d_rdata !== ref1[18'h00020]) begin
            failures++; $display("FAIL rm_reads: got %h %h expected %h %h", c_rdata, d_rdata, ref1[18'h00010], ref1[18'h00020]);
        end
        model_last = 1'b1;
        run_access(1'b0, 18'h00010, 2'b00, 16'h0000, 1'b0, rd, lat);
        checks++;
        if (lat !== 3 || rd !== ref1[18'h00010]) begin
            failures++; $display("FAIL rm_after: got lat %0d data %h expected 3 %h", lat, rd, ref1[18'h00010]);
        end
    endtask

    task automatic test_wait0();
        int t [3];
        logic [15:0] rds [3];
        logic [15:0] exp_rd [3];
        int cyc = 0, n = 0, o1 = -1;
        mem0[18'h3FFFF] = 16'hBEEF; mem0[18'h00000] = 16'h2222; mem0[18'h3FFFE] = 16'h1111;
        exp_rd[0] = 16'hBEEF; exp_rd[1] = 16'h2222; exp_rd[2] = 16'h1111;
        oen0_cnt = 0;
        @(posedge clk); #1;
        d_addr0 = 18'h3FFFF; d_we0 = 2'b00; d_req0 = 1'b1;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (d_ack0) begin
                t[n] = cyc; rds[n] = d_rdata0; n++;
                if (n == 1) o1 = oen0_cnt;
                d_addr0 = (n == 1) ? 18'h00000 : 18'h3FFFE;
                if (n == 3) d_req0 = 1'b0;
            end
        end
        d_req0 = 1'b0;
        checks++;
        if (n !== 3) begin
            failures++; $display("FAIL w0_acks: got %0d expected 3", n);
        end else begin
            checks++;
            if (t[0] !== 2) begin failures++; $display("FAIL w0_latency: got %0d expected 2", t[0]); end
            checks++;
            if (o1 !== 1) begin failures++; $display("FAIL w0_oe_width: got %0d expected 1", o1); end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rds[k] !== exp_rd[k]) begin failures++; $display("FAIL w0_read[%0d]: got %h expected %h", k, rds[k], exp_rd[k]); end
            end
            checks++;
            if (t[1] - t[0] !== 3 || t[2] - t[1] !== 3) begin
                failures++; $display("FAIL w0_spacing: got %0d %0d expected 3 3", t[1] - t[0], t[2] - t[1]);
            end
        end
        checks++;
        if (c_rdata0 !== 16'h0) begin failures++; $display("FAIL w0_c_rdata: got %h expected 0000", c_rdata0); end
    endtask

    initial begin
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        c_req0 = 0; c_we0 = 0; c_addr0 = 0; c_wdata0 = 0;
        d_req0 = 0; d_we0 = 0; d_addr0 = 0; d_wdata0 = 0;
        nreset = 1'b0;
        test_reset();
        test_word_write();
        test_byte_write_read();
        test_contention();
        test_random();
        test_reset_mid();
        test_wait0();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
